// File: rtl/rv32_pkg.sv
// Shared fetch-stage types: FSM states, queue entry layout and address helpers.
package rv32_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            filled;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit boundary: imem request/response, redirect from execute, decode handoff.
interface instr_fetch_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  imem_req_valid;
   logic [DATA_WIDTH-1:0] imem_req_addr;
   logic                  imem_req_ready;
   logic                  imem_rsp_valid;
   logic [DATA_WIDTH-1:0] imem_rsp_data;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instr;
   logic [DATA_WIDTH-1:0] instr_pc;
   logic                  instr_ready;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order slot ring: tail allocates on request accept, fill pointer tracks the
// oldest slot still waiting for its response, head feeds decode.
module fetch_queue
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IW   = $clog2(DEPTH),
   localparam int PW   = IW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill,
   input  logic [XLEN-1:0] fill_data,
   input  logic            pop,
   input  logic            flush,
   output fetch_entry_t    head,
   output logic [PW-1:0]   count,
   output logic [PW-1:0]   outstanding
);

   fetch_entry_t  slots [DEPTH];
   logic [PW-1:0] head_ptr, tail_ptr, fill_ptr;

   // Pointers carry one extra wrap bit so a full ring is distinguishable from empty.
   assign head        = slots[head_ptr[IW-1:0]];
   assign count       = tail_ptr - head_ptr;
   assign outstanding = tail_ptr - fill_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
      end else begin
         if (alloc) begin
            slots[tail_ptr[IW-1:0]] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
            tail_ptr <= tail_ptr + PW'(1);
         end
         if (fill) begin
            slots[fill_ptr[IW-1:0]].instr  <= fill_data;
            slots[fill_ptr[IW-1:0]].filled <= 1'b1;
            fill_ptr <= fill_ptr + PW'(1);
         end
         if (pop) begin
            slots[head_ptr[IW-1:0]].filled <= 1'b0;
            head_ptr <= head_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, streams word reads to imem, buffers results for decode
// and flushes/restarts on redirect while discarding responses already in flight.
module instr_fetch_unit
   import rv32_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    QUEUE_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  bus
);

   localparam int PW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_e          state;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [PW-1:0]         stale_cnt;
   logic [PW-1:0]         count;
   logic [PW-1:0]         outstanding;
   logic [PW-1:0]         redirect_stale;
   fetch_entry_t          head;
   logic                  pop, slot_free, accept, fill, rsp_stale;

   assign pop       = head.filled && bus.instr_ready;
   assign slot_free = (count != PW'(QUEUE_DEPTH)) || pop;
   assign rsp_stale = (stale_cnt != '0);
   assign accept    = bus.imem_req_valid && bus.imem_req_ready;
   // A response arriving with the redirect belongs to the old path and is dropped.
   assign fill      = bus.imem_rsp_valid && !rsp_stale && !bus.redirect_valid
                      && (outstanding != '0);

   assign bus.imem_req_valid = (state == FETCH) && slot_free && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.instr_valid    = head.filled;
   assign bus.instr          = head.instr;
   assign bus.instr_pc       = head.pc;

   // Everything requested but not yet answered becomes stale on redirect.
   always_comb begin
      redirect_stale = stale_cnt + outstanding;
      if (bus.imem_rsp_valid && (redirect_stale != '0))
         redirect_stale = redirect_stale - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         stale_cnt <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc  <= word_align(bus.redirect_pc);
         stale_cnt <= redirect_stale;
         state     <= (redirect_stale != '0) ? DRAIN : FETCH;
      end else begin
         if (accept)
            fetch_pc <= fetch_pc + DATA_WIDTH'(INSTR_BYTES);
         if (bus.imem_rsp_valid && rsp_stale)
            stale_cnt <= stale_cnt - PW'(1);
         case (state)
            IDLE:    state <= FETCH;
            FETCH:   state <= FETCH;
            DRAIN:   if (!rsp_stale || (stale_cnt == PW'(1) && bus.imem_rsp_valid))
                        state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .alloc       (accept),
      .alloc_pc    (fetch_pc),
      .fill        (fill),
      .fill_data   (bus.imem_rsp_data),
      .pop         (pop),
      .flush       (bus.redirect_valid),
      .head        (head),
      .count       (count),
      .outstanding (outstanding)
   );

   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rsp_valid |-> (rsp_stale || outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench: in-order latency memory model, expected sequential instruction
// stream per reset/redirect, and an address-stream model for the request side.
module tb_instr_fetch_unit;
   import rv32_pkg::*;

   localparam int          QD       = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

   instr_fetch_unit #(
      .DATA_WIDTH  (32),
      .QUEUE_DEPTH (QD),
      .RESET_PC    (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        exp_q [$];
   rsp_t        pend_q [$];
   int          cyc, errors, checks, stale_tb, occ, acc_cnt, hs_cnt, first_valid;
   int          lat_min = 1, lat_max = 1, ready_pct = 100;
   logic [31:0] exp_req_pc;
   bit          prev_redir;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sequential program the fetch unit must deliver from a given start PC.
   task automatic load_stream(input logic [31:0] pc);
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         exp_t e;
         e.pc    = pc + 32'(4 * i);
         e.instr = mem_word(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic mem_tick();
      bus.imem_req_ready = (int'($urandom_range(99)) < ready_pct);
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = pend_q[0].data;
         void'(pend_q.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.redirect_valid) begin
         load_stream({bus.redirect_pc[31:2], 2'b00});
         exp_req_pc = {bus.redirect_pc[31:2], 2'b00};
         stale_tb   = pend_q.size();
         occ        = 0;
      end
      mem_tick();
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      pend_q.delete();
      exp_q.delete();
      tick();
      tick();
      #1;
      chk("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr",       bus.instr, 32'd0);
      chk("rst_instr_pc",    bus.instr_pc, 32'd0);
      rst         = 1'b0;
      cyc         = 0;
      exp_req_pc  = RESET_PC;
      load_stream(RESET_PC);
      stale_tb    = 0;
      occ         = 0;
      prev_redir  = 1'b0;
      first_valid = -1;
      acc_cnt     = 0;
      hs_cnt      = 0;
   endtask

   // Monitor: samples mid-cycle, checks outputs against the models, updates them.
   always @(negedge clk) begin
      logic hs, acc;
      rsp_t r;
      if (!rst) begin
         hs  = bus.instr_valid && bus.instr_ready;
         acc = bus.imem_req_valid && bus.imem_req_ready;
         if (prev_redir)         chk("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
         if (bus.redirect_valid) chk("req_during_redirect", 32'(bus.imem_req_valid), 32'd0);
         if (stale_tb != 0)      chk("req_during_drain", 32'(bus.imem_req_valid), 32'd0);
         if (bus.instr_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL instr_unexpected: got pc 0x%08h, no instruction expected", bus.instr_pc);
            end else begin
               chk("instr_pc", bus.instr_pc, exp_q[0].pc);
               chk("instr",    bus.instr,    exp_q[0].instr);
               if (hs) void'(exp_q.pop_front());
            end
         end
         if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req_pc);
         if (acc) begin
            checks++;
            if (occ - int'(hs) >= QD) begin
               errors++;
               $display("FAIL slot_limit: accept with %0d slots held, want < %0d", occ - int'(hs), QD);
            end
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            r.data = mem_word(bus.imem_req_addr);
            pend_q.push_back(r);
            exp_req_pc = exp_req_pc + 32'd4;
            acc_cnt++;
            occ++;
         end
         if (hs) begin
            hs_cnt++;
            occ--;
         end
         if (bus.imem_rsp_valid && stale_tb != 0 && !bus.redirect_valid) stale_tb--;
         if (bus.instr_valid && first_valid < 0) first_valid = cyc;
         prev_redir = bus.redirect_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int h0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
      errors = 0;
      checks = 0;
      cyc    = 0;

      // Streaming with single-cycle memory.
      do_reset();
      bus.instr_ready = 1'b1;
      repeat (23) tick();
      chk("first_valid_cycle", 32'(first_valid), 32'd3);
      chk("throughput_20",     32'(hs_cnt), 32'd20);

      // Decode backpressure: queue fills to four, then resumes in order.
      do_reset();
      bus.instr_ready = 1'b0;
      repeat (12) tick();
      #1;
      chk("bp_accepts",  32'(acc_cnt), 32'd4);
      chk("bp_req_stop", 32'(bus.imem_req_valid), 32'd0);
      bus.instr_ready = 1'b1;
      repeat (20) tick();

      // Memory not ready for three cycles: request held at 0x8.
      do_reset();
      bus.instr_ready = 1'b1;
      tick();
      tick();
      ready_pct = 0;
      repeat (3) begin
         tick();
         #1;
         chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
         chk("stall_req_addr",  bus.imem_req_addr, 32'h8);
      end
      ready_pct = 100;
      repeat (10) tick();

      // Redirect to 0x103 with two requests in flight on a 3-cycle memory.
      do_reset();
      lat_min = 3;
      lat_max = 3;
      bus.instr_ready = 1'b1;
      repeat (3) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      tick();
      bus.redirect_valid = 1'b0;
      repeat (25) tick();
      chk("redirect_progress", 32'(hs_cnt != 0), 32'd1);

      // Redirect together with a response and a decode handshake.
      do_reset();
      lat_min = 1;
      lat_max = 1;
      bus.instr_ready = 1'b1;
      repeat (8) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      #1;
      chk("same_cycle_rsp_valid",   32'(bus.imem_rsp_valid), 32'd1);
      chk("same_cycle_instr_valid", 32'(bus.instr_valid), 32'd1);
      tick();
      bus.redirect_valid = 1'b0;
      repeat (10) tick();

      // PC wrap past the top of the address space.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      tick();
      bus.redirect_valid = 1'b0;
      repeat (12) tick();

      // Reset while draining stale responses.
      lat_min = 3;
      lat_max = 3;
      do_reset();
      bus.instr_ready = 1'b1;
      repeat (3) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      tick();
      bus.redirect_valid = 1'b0;
      lat_min = 1;
      lat_max = 1;
      do_reset();
      repeat (10) tick();
      chk("post_reset_progress", 32'(hs_cnt != 0), 32'd1);

      // Randomized traffic.
      lat_min   = 1;
      lat_max   = 4;
      ready_pct = 70;
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         tick();
         if ($urandom_range(999) < 4) begin
            do_reset();
            continue;
         end
         bus.instr_ready    = ($urandom_range(99) < 70);
         bus.redirect_valid = ($urandom_range(99) < 3);
         bus.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                       : $urandom;
      end

      // Settle and confirm one instruction per cycle.
      bus.redirect_valid = 1'b0;
      bus.instr_ready    = 1'b1;
      lat_min   = 1;
      lat_max   = 1;
      ready_pct = 100;
      repeat (20) tick();
      h0 = hs_cnt;
      repeat (20) tick();
      chk("steady_throughput", 32'(hs_cnt - h0), 32'd20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
